// File: rtl/imem_loader.sv
// imem_loader
// Boot-time program loader. Receives a framed byte stream
// (LEN_LO, LEN_HI, 4*N payload bytes LSB-first, CSUM) over a valid/ready
// handshake, assembles 32-bit little-endian words and writes them to
// instruction memory at consecutive word addresses starting at BASE_ADDR.
// The core is held in reset until a complete, checksum-verified program
// has been written.
//
// Ports:
//   clk        - rising-edge clock
//   reset      - asynchronous, active-low reset
//   start      - begin a load (IDLE) or restart one (DONE / ERROR)
//   in_valid   - byte source has a byte on in_byte
//   in_byte    - stream byte
//   in_ready   - loader accepts a byte this cycle (decoded from state)
//   wr_en      - one-cycle instruction memory write strobe
//   wr_addr    - word-aligned byte address of the write
//   wr_data    - instruction word
//   core_hold  - 1 keeps the core in reset; low only once a load is verified
//   done       - load completed and verified
//   err        - load rejected (bad length or bad checksum)
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        in_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        core_hold,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

    state_t      state_q, state_d;
    logic [7:0]  sum_q,   sum_d;
    logic [1:0]  lane_q,  lane_d;
    logic [15:0] k_q,     k_d;
    logic [15:0] len_q,   len_d;
    logic [23:0] word_q,  word_d;    // lanes 0..2; lane 3 comes straight from in_byte
    logic        wr_en_q, wr_en_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;

    logic        accept;
    logic [7:0]  sum_next;
    logic [15:0] len_in;
    logic        len_ok;

    assign in_ready = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                      (state_q == S_DATA)   || (state_q == S_CSUM);
    assign accept   = in_valid && in_ready;
    assign sum_next = sum_q + in_byte;
    assign len_in   = {in_byte, len_q[7:0]};
    assign len_ok   = (len_in != 16'd0) && ({1'b0, len_in} <= MAX_W);

    always_comb begin
        state_d   = state_q;
        sum_d     = sum_q;
        lane_d    = lane_q;
        k_d       = k_q;
        len_d     = len_q;
        word_d    = word_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_LEN_LO;
                    sum_d   = 8'd0;
                    lane_d  = 2'd0;
                    k_d     = 16'd0;
                    len_d   = 16'd0;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d[7:0] = in_byte;
                    sum_d      = sum_next;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_d   = len_in;
                    sum_d   = sum_next;
                    state_d = len_ok ? S_DATA : S_ERROR;
                end
            end
            S_DATA: begin
                if (accept) begin
                    sum_d  = sum_next;
                    lane_d = lane_q + 2'd1;
                    case (lane_q)
                        2'd0: word_d[7:0]   = in_byte;
                        2'd1: word_d[15:8]  = in_byte;
                        2'd2: word_d[23:16] = in_byte;
                        default: begin
                            // Word complete: register the write, advance index.
                            wr_en_d   = 1'b1;
                            wr_data_d = {in_byte, word_q};
                            wr_addr_d = BASE_ADDR + {14'd0, k_q, 2'b00};
                            k_d       = k_q + 16'd1;
                            if ((k_q + 16'd1) == len_q) begin
                                state_d = S_CSUM;
                            end
                        end
                    endcase
                end
            end
            S_CSUM: begin
                if (accept) begin
                    sum_d   = sum_next;
                    state_d = (sum_next == 8'd0) ? S_DONE : S_ERROR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            sum_q     <= 8'd0;
            lane_q    <= 2'd0;
            k_q       <= 16'd0;
            len_q     <= 16'd0;
            word_q    <= 24'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= BASE_ADDR;
            wr_data_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            sum_q     <= sum_d;
            lane_q    <= lane_d;
            k_q       <= k_d;
            len_q     <= len_d;
            word_q    <= word_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    // Status is a pure decode of state, so done and core_hold switch together.
    assign done      = (state_q == S_DONE);
    assign err       = (state_q == S_ERROR);
    assign core_hold = (state_q != S_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: directed steps plus randomized frames, checked
// against a frame-level reference model (byte positions, word indices and
// the 8-bit frame sum computed directly from the frame contents).
module tb_imem_loader;
    typedef logic [7:0]  bq_t [$];
    typedef logic [31:0] wq_t [$];

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          MAXW = 256;

    logic        clk = 1'b0;
    logic        reset, start, in_valid;
    logic [7:0]  in_byte;
    logic        in_ready, wr_en, core_hold, done, err;
    logic [31:0] wr_addr, wr_data;

    int checks = 0;
    int failures = 0;
    logic [31:0] last_addr = BASE;
    logic [31:0] last_data = 32'd0;

    always #5 clk = ~clk;

    imem_loader dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_byte(in_byte), .in_ready(in_ready), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .core_hold(core_hold),
        .done(done), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bq_t build(input wq_t w, input bit bad_csum);
        bq_t q;
        logic [7:0] s;
        logic [15:0] n;
        n = 16'(w.size());
        q.push_back(n[7:0]);
        q.push_back(n[15:8]);
        foreach (w[j]) begin
            logic [31:0] x;
            x = w[j];
            q.push_back(x[7:0]);
            q.push_back(x[15:8]);
            q.push_back(x[23:16]);
            q.push_back(x[31:24]);
        end
        s = 8'd0;
        foreach (q[i]) s = s + q[i];
        s = 8'd0 - s;
        if (bad_csum) s = s + 8'd1;
        q.push_back(s);
        return q;
    endfunction

    // Called at a negedge. Pulses start (optionally with a simultaneous byte
    // that must be ignored) and checks the freshly started load state.
    task automatic do_start(input bit with_byte);
        start = 1'b1;
        in_valid = with_byte;
        in_byte = 8'h5A;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b0;
        chk("start_in_ready", in_ready, 1);
        chk("start_done", done, 0);
        chk("start_err", err, 0);
        chk("start_hold", core_hold, 1);
    endtask

    // Called at a negedge. Sends the first nsend bytes of fr.
    // gap_mode: 0 none, 1 alternate valid/idle, 2 random idles.
    task automatic send_frame(input bq_t fr, input int gap_mode, input int nsend);
        int n, i, p;
        bit len_ok, tog, gap, nxt;
        logic [31:0] ea, ed;
        logic [7:0] s;
        n = int'({fr[1], fr[0]});
        len_ok = (n >= 1) && (n <= MAXW);
        i = 0;
        tog = 1'b0;
        while (i < nsend) begin
            gap = (gap_mode == 1) ? tog : (gap_mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
            tog = ~tog;
            nxt = 1'b0;
            ea = 32'd0;
            ed = 32'd0;
            if (gap) begin
                in_valid = 1'b0;
                in_byte = 8'($urandom);
                @(posedge clk);
            end else begin
                chk("busy_in_ready", in_ready, 1);
                chk("busy_hold", core_hold, 1);
                chk("busy_done", done, 0);
                in_valid = 1'b1;
                in_byte = fr[i];
                @(posedge clk);
                p = i - 2;
                if (len_ok && p >= 0 && p < 4 * n && (p % 4) == 3) begin
                    nxt = 1'b1;
                    ea = BASE + 32'(4 * (p / 4));
                    ed = {fr[i], fr[i-1], fr[i-2], fr[i-3]};
                end
                i++;
            end
            @(negedge clk);
            chk("wr_en", wr_en, nxt);
            if (nxt) begin
                chk("wr_addr", wr_addr, ea);
                chk("wr_data", wr_data, ed);
                last_addr = ea;
                last_data = ed;
            end
        end
        in_valid = 1'b0;
        if (!len_ok || nsend == fr.size()) begin
            s = 8'd0;
            for (int j = 0; j < nsend; j++) s = s + fr[j];
            chk("end_done", done, (len_ok && s == 8'd0));
            chk("end_err", err, !(len_ok && s == 8'd0));
            chk("end_hold", core_hold, !(len_ok && s == 8'd0));
            chk("end_in_ready", in_ready, 0);
            @(negedge clk);
            chk("end_wr_en", wr_en, 0);
            chk("hold_addr", wr_addr, last_addr);
            chk("hold_data", wr_data, last_data);
        end
    endtask

    initial begin
        bq_t f;
        wq_t w;
        reset = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        in_byte = 8'd0;
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, BASE);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_hold", core_hold, 1);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // IDLE ignores bytes.
        in_valid = 1'b1;
        in_byte = 8'h01;
        repeat (2) @(negedge clk);
        chk("idle_in_ready", in_ready, 0);
        chk("idle_wr_en", wr_en, 0);
        in_valid = 1'b0;

        // Single word; start with a simultaneous byte.
        do_start(1'b1);
        w = '{32'h0000_0013};
        f = build(w, 1'b0);
        send_frame(f, 0, f.size());

        // Restart from DONE with two words and back-pressure.
        do_start(1'b0);
        w = '{32'h0050_0093, 32'h0020_8133};
        f = build(w, 1'b0);
        send_frame(f, 1, f.size());

        // Bad lengths.
        do_start(1'b0);
        f = '{8'h00, 8'h00};
        send_frame(f, 0, 2);
        do_start(1'b0);
        f = '{8'h01, 8'h01};
        send_frame(f, 0, 2);

        // Bad checksum: write still issued.
        do_start(1'b0);
        w = '{32'h0000_0013};
        f = build(w, 1'b1);
        send_frame(f, 0, f.size());

        // Randomized frames.
        for (int r = 0; r < 8; r++) begin
            int n;
            do_start(1'($urandom));
            n = $urandom_range(1, 8);
            w = {};
            for (int j = 0; j < n; j++) w.push_back($urandom);
            f = build(w, ($urandom_range(0, 3) == 0));
            send_frame(f, $urandom_range(0, 2), f.size());
        end

        // Maximum length.
        do_start(1'b0);
        w = {};
        for (int j = 0; j < MAXW; j++) w.push_back($urandom);
        f = build(w, 1'b0);
        send_frame(f, 0, f.size());

        // Reset after 3 payload bytes.
        do_start(1'b0);
        w = '{32'h0000_0013};
        f = build(w, 1'b0);
        send_frame(f, 0, 5);
        reset = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_wr_en", wr_en, 0);
        chk("mid_rst_wr_addr", wr_addr, BASE);
        chk("mid_rst_wr_data", wr_data, 0);
        chk("mid_rst_hold", core_hold, 1);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_err", err, 0);
        last_addr = BASE;
        last_data = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b1;
        in_byte = 8'h00;
        repeat (2) @(negedge clk);
        chk("post_rst_in_ready", in_ready, 0);
        chk("post_rst_wr_en", wr_en, 0);
        in_valid = 1'b0;
        do_start(1'b0);
        send_frame(f, 2, f.size());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader and the write-side counterpart of the core's instruction fetch path. It accepts a framed byte stream from a byte source (e.g. a UART receiver) over a valid/ready handshake and assembles little-endian 32-bit instruction words. It writes those words into instruction memory at consecutive word addresses and holds the core in reset until a complete, checksum-verified program has been written.

## Interface
- `BASE_ADDR`, default 32'h0000_0000: byte address of the first instruction word written.
- `MAX_WORDS`, default 256: largest accepted word count. Must be ≤ 65535.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low. 0 means in reset.
- `start` in 1: begins a load from IDLE; restarts a load from DONE or ERROR.
- `in_valid` in 1: byte source has a byte on `in_byte`.
- `in_byte` in 8: stream byte.
- `in_ready` out 1: loader accepts a byte this cycle.
- `wr_en` out 1: instruction memory write strobe, one cycle per word.
- `wr_addr` out 32: byte address of the write, word aligned.
- `wr_data` out 32: instruction word.
- `core_hold` out 1: 1 keeps the core in reset (drives the core's `reset`).
- `done` out 1: load completed and verified.
- `err` out 1: load rejected.

## Operation
- **Frame format:** LEN_LO, LEN_HI, then 4·N payload bytes, then CSUM.
  - N = {LEN_HI, LEN_LO}.
  - Each word is sent LSB byte first.
  - CSUM is chosen so that the 8-bit sum of every frame byte, CSUM included, equals 0 (mod 256).
- **Byte acceptance:** a byte is accepted on a rising edge where `in_valid && in_ready`. Nothing else advances the FSM except `start`.
- **FSM states:** IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERROR.
  - IDLE: `in_ready`=0. `start`=1 → LEN_LO.
  - LEN_LO: accept → LEN_HI.
  - LEN_HI: accept → DATA if 1 ≤ N ≤ MAX_WORDS, else ERROR.
  - DATA: accept 4·N bytes. The accept of the final byte → CSUM.
  - CSUM: accept → DONE if the running sum plus CSUM ≡ 0, else ERROR.
  - DONE and ERROR: `in_ready`=0. `start`=1 → LEN_LO. Entering LEN_LO clears `done`/`err`, sets `core_hold`=1, and clears the sum and counters.
  - `start` is ignored in LEN_LO, LEN_HI, DATA and CSUM.
- **Datapath:**
  - An 8-bit running sum accumulates every accepted byte from LEN_LO onward.
  - A 2-bit byte lane counter places each byte into lane 0..3 of the word register.
  - A 16-bit word index k counts words written.
- **Write:** `wr_data` = {b3,b2,b1,b0}; `wr_addr` = BASE_ADDR + 4·k, truncated to 32 bits.
- **in_ready:** combinational from state. 1 in LEN_LO, LEN_HI, DATA and CSUM, 0 otherwise.
- **core_hold:** 1 in every state except DONE. It is never released on ERROR.
- **Reset values:** state IDLE, `in_ready`=0, `wr_en`=0, `wr_addr`=BASE_ADDR, `wr_data`=0, `core_hold`=1, `done`=0, `err`=0. Sum, lane and word counters are all 0.

## Timing
- **Word write latency:** `wr_en` is registered. It is high for exactly one cycle, the cycle after the edge that accepts lane 3. `wr_addr`/`wr_data` are valid in that cycle and hold until the next write.
- **Last word:** the write of the final word occurs in the first CSUM cycle, and is issued even if the load later ends in ERROR.
- **Status outputs:** `done`/`err` go high and `core_hold` goes low on the edge that accepts CSUM. They are visible in the following cycle. `core_hold` and `done` switch together.
- **Throughput:** one byte per cycle with `in_valid` held high. Gaps in `in_valid` only stall; they never corrupt lane or count.
- **Length rejection:** an invalid N is detected on the LEN_HI accept. No `wr_en` is issued for that frame.
- **Reset mid-load:** asserting `reset` immediately forces all reset values. A partially assembled word is discarded with no `wr_en`, and a fresh `start` is required afterwards.
- **Simultaneous events:** `start` and `in_valid` together in IDLE → only the state change happens; the byte is not accepted because `in_ready`=0 that cycle.

## Test plan
- **Single word:** reset, `start`, stream 01 00 13 00 00 00 EC → one `wr_en` with addr 0x0, data 0x00000013; then `done`=1, `core_hold`=0, `err`=0.
- **Two words with back-pressure:** stream 02 00 93 00 50 00 33 81 20 00 47 with `in_valid` toggling 1/0 → writes (0x0, 0x00500093) and (0x4, 0x00208133), each `wr_en` lasting one cycle; then `done`=1.
- **Bad length:** LEN 00 00 → ERROR after the 2nd byte. Likewise LEN 01 01 (N=257, MAX_WORDS=256) → ERROR. In both cases `err`=1, `core_hold`=1, no `wr_en`, `in_ready`=0.
- **Bad checksum:** stream 01 00 13 00 00 00 ED → write (0x0, 0x13) still occurs; then `err`=1, `done`=0, `core_hold`=1.
- **Reset mid-load:** assert `reset` after 3 payload bytes → outputs return to reset values immediately with no write. Then `start` plus the full single-word frame → `done`=1.
- **Restart:** `start` in DONE, then the two-word frame → `done` clears, `core_hold`=1 until the new CSUM, and writes begin again at BASE_ADDR.
